// File: rtl/egr_latency_tbl_if.sv
// rtl/egr_latency_tbl_if.sv - control, measurement stream and result bundle for egr_latency_tbl
interface egr_latency_tbl_if #(
  parameter int CID_WIDTH   = 10,
  parameter int TS_WIDTH    = 48,
  parameter int TDATA_WIDTH = 136
) ();
  logic                   cfg_clear;
  logic                   egr_meas_start_tready;
  logic                   egr_meas_start_tvalid;
  logic [TDATA_WIDTH-1:0] egr_meas_start_tdata;
  logic                   egr_meas_end_tready;
  logic                   egr_meas_end_tvalid;
  logic [TDATA_WIDTH-1:0] egr_meas_end_tdata;
  logic                   egr_latency_valid;
  logic [TS_WIDTH-1:0]    egr_latency_data;
  logic [CID_WIDTH-1:0]   egr_latency_cid;
  logic                   err_stop_mishit;
  logic                   err_start_overrun;
  logic                   init_done;

  modport slave (
    input  cfg_clear,
    input  egr_meas_start_tvalid, egr_meas_start_tdata,
    output egr_meas_start_tready,
    input  egr_meas_end_tvalid, egr_meas_end_tdata,
    output egr_meas_end_tready,
    output egr_latency_valid, egr_latency_data, egr_latency_cid,
    output err_stop_mishit, err_start_overrun, init_done
  );

  modport master (
    output cfg_clear,
    output egr_meas_start_tvalid, egr_meas_start_tdata,
    input  egr_meas_start_tready,
    output egr_meas_end_tvalid, egr_meas_end_tdata,
    input  egr_meas_end_tready,
    input  egr_latency_valid, egr_latency_data, egr_latency_cid,
    input  err_stop_mishit, err_start_overrun, init_done
  );
endinterface

// File: rtl/egr_latency_tbl.sv
// rtl/egr_latency_tbl.sv - per-cid start/end latency table; EGR_LATENCY_TBL_STAT_EN adds hit statistics
module egr_latency_tbl #(
  parameter int CID_WIDTH    = 10,
  parameter int SN_WIDTH     = 32,
  parameter int TS_WIDTH     = 48,
  parameter int TDATA_WIDTH  = 136,
  parameter int START_SN_LSB = 64,
  parameter int STOP_SN_LSB  = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  egr_latency_tbl_if.slave    bus
`ifdef EGR_LATENCY_TBL_STAT_EN
  ,
  output logic [31:0]         stat_count,
  output logic [TS_WIDTH-1:0] stat_min,
  output logic [TS_WIDTH-1:0] stat_max
`endif
);

  localparam int DEPTH = 1 << CID_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [CID_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                 init_clr;
  logic                 run;
  logic                 clear_req;

  logic [TS_WIDTH-1:0]  ts_q;

  logic [DEPTH-1:0]     tbl_vld_q;
  logic [SN_WIDTH-1:0]  tbl_sn_q [DEPTH];
  logic [TS_WIDTH-1:0]  tbl_ts_q [DEPTH];

  logic                 start_acc, end_acc;
  logic [CID_WIDTH-1:0] start_cid, end_cid;
  logic [SN_WIDTH-1:0]  start_sn, end_sn;
  logic                 lookup_vld;
  logic                 unused_tdata;

  // End pipeline stage 1: captured event plus the table entry read at accept
  logic                 s1_vld_q;
  logic [CID_WIDTH-1:0] s1_cid_q;
  logic [SN_WIDTH-1:0]  s1_sn_q;
  logic [TS_WIDTH-1:0]  s1_ts_q;
  logic                 s1_ent_vld_q;
  logic [SN_WIDTH-1:0]  s1_ent_sn_q;
  logic [TS_WIDTH-1:0]  s1_ent_ts_q;
  logic                 s1_keep_q;

  logic                 s2_hit, s2_clr;

  logic                 s2_lat_vld_q;
  logic                 s2_miss_q;
  logic [CID_WIDTH-1:0] s2_cid_q;
  logic [TS_WIDTH-1:0]  s2_lat_q;

  logic                 lat_vld_q;
  logic [TS_WIDTH-1:0]  lat_data_q;
  logic [CID_WIDTH-1:0] lat_cid_q;
  logic                 mishit_q;
  logic                 overrun_q;

  assign run       = (state_q == ST_RUN);
  assign clear_req = run & bus.cfg_clear;

  assign start_acc = bus.egr_meas_start_tvalid & run;
  assign start_cid = bus.egr_meas_start_tdata[CID_WIDTH-1:0];
  assign start_sn  = bus.egr_meas_start_tdata[START_SN_LSB +: SN_WIDTH];
  assign end_acc   = bus.egr_meas_end_tvalid & run;
  assign end_cid   = bus.egr_meas_end_tdata[CID_WIDTH-1:0];
  assign end_sn    = bus.egr_meas_end_tdata[STOP_SN_LSB +: SN_WIDTH];

  // Only cid and SN fields are meaningful; the rest of tdata is ignored.
  assign unused_tdata = ^{bus.egr_meas_start_tdata, bus.egr_meas_end_tdata};

  // A start accepted on the same edge as this entry's lookup has already replaced it,
  // so the hit must not clear the freshly written entry.
  assign s2_hit = s1_vld_q & s1_ent_vld_q & (s1_ent_sn_q == s1_sn_q);
  assign s2_clr = s2_hit & ~s1_keep_q;

  // A lookup racing the clear of the same cid must not see the consumed entry.
  assign lookup_vld = tbl_vld_q[end_cid] & ~(s2_clr & (s1_cid_q == end_cid));

  // Init/run state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Init sweeps every address once; cfg_clear restarts the sweep from RUN only
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_clr    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_clr = 1'b1;
        if (init_addr_q == '1) begin
          state_d     = ST_RUN;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + CID_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (bus.cfg_clear) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Free-running timestamp, wraps modulo 2^TS_WIDTH
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) ts_q <= '0;
    else           ts_q <= ts_q + TS_WIDTH'(1);
  end

  // Valid bits: init and hit clears first, start write last so it wins any collision
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tbl_vld_q <= '0;
    end else begin
      if (init_clr)  tbl_vld_q[init_addr_q] <= 1'b0;
      if (s2_clr)    tbl_vld_q[s1_cid_q]    <= 1'b0;
      if (start_acc) tbl_vld_q[start_cid]   <= 1'b1;
    end
  end

  // Entry payload is only meaningful while its valid bit is set
  always_ff @(posedge ap_clk) begin
    if (start_acc) begin
      tbl_sn_q[start_cid] <= start_sn;
      tbl_ts_q[start_cid] <= ts_q;
    end
  end

  // Stage 1: register end event and read-first table lookup
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_cid_q     <= '0;
      s1_sn_q      <= '0;
      s1_ts_q      <= '0;
      s1_ent_vld_q <= 1'b0;
      s1_ent_sn_q  <= '0;
      s1_ent_ts_q  <= '0;
      s1_keep_q    <= 1'b0;
    end else begin
      s1_vld_q     <= end_acc;
      s1_cid_q     <= end_cid;
      s1_sn_q      <= end_sn;
      s1_ts_q      <= ts_q;
      s1_ent_vld_q <= lookup_vld;
      s1_ent_sn_q  <= tbl_sn_q[end_cid];
      s1_ent_ts_q  <= tbl_ts_q[end_cid];
      s1_keep_q    <= start_acc & end_acc & (start_cid == end_cid);
    end
  end

  // Stage 2: hit/miss decision and modular latency
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_lat_vld_q <= 1'b0;
      s2_miss_q    <= 1'b0;
      s2_cid_q     <= '0;
      s2_lat_q     <= '0;
    end else begin
      s2_lat_vld_q <= s2_hit;
      s2_miss_q    <= s1_vld_q & ~s2_hit;
      s2_cid_q     <= s1_cid_q;
      s2_lat_q     <= s1_ts_q - s1_ent_ts_q;
    end
  end

  // Output registers: result strobe and error pulses
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lat_vld_q  <= 1'b0;
      lat_data_q <= '0;
      lat_cid_q  <= '0;
      mishit_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      lat_vld_q  <= s2_lat_vld_q;
      mishit_q   <= s2_miss_q;
      overrun_q  <= start_acc & tbl_vld_q[start_cid];
      if (s2_lat_vld_q) begin
        lat_data_q <= s2_lat_q;
        lat_cid_q  <= s2_cid_q;
      end
    end
  end

  assign bus.egr_meas_start_tready = run;
  assign bus.egr_meas_end_tready   = run;
  assign bus.init_done             = run;
  assign bus.egr_latency_valid     = lat_vld_q;
  assign bus.egr_latency_data      = lat_data_q;
  assign bus.egr_latency_cid       = lat_cid_q;
  assign bus.err_stop_mishit       = mishit_q;
  assign bus.err_start_overrun     = overrun_q;

`ifdef EGR_LATENCY_TBL_STAT_EN
  logic [31:0]         stat_count_q;
  logic [TS_WIDTH-1:0] stat_min_q, stat_max_q;

  // Hit statistics track the results as they are published; cfg_clear restarts them
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_count_q <= '0;
      stat_min_q   <= '1;
      stat_max_q   <= '0;
    end else if (clear_req) begin
      stat_count_q <= '0;
      stat_min_q   <= '1;
      stat_max_q   <= '0;
    end else if (s2_lat_vld_q) begin
      if (stat_count_q != '1)     stat_count_q <= stat_count_q + 32'd1;
      if (s2_lat_q < stat_min_q)  stat_min_q   <= s2_lat_q;
      if (s2_lat_q > stat_max_q)  stat_max_q   <= s2_lat_q;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_min   = stat_min_q;
  assign stat_max   = stat_max_q;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
`endif

endmodule

// File: tb/tb_egr_latency_tbl.sv
// tb/tb_egr_latency_tbl.sv - scoreboard bench for egr_latency_tbl (CID_WIDTH=4, TS_WIDTH=8)
module tb_egr_latency_tbl;

  localparam int CW = 4;
  localparam int SW = 16;
  localparam int TW = 8;
  localparam int DW = 64;

  typedef struct {
    bit          miss;
    logic [CW-1:0] cid;
    logic [TW-1:0] data;
    int          cyc;
  } exp_t;

  logic ap_clk = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  logic [TW-1:0] tb_ts;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_seen = 0;
  exp_t exp_q[$];

  egr_latency_tbl_if #(.CID_WIDTH(CW), .TS_WIDTH(TW), .TDATA_WIDTH(DW)) bus ();

`ifdef EGR_LATENCY_TBL_STAT_EN
  logic [31:0]   stat_count;
  logic [TW-1:0] stat_min, stat_max;
`endif

  egr_latency_tbl #(
    .CID_WIDTH(CW), .SN_WIDTH(SW), .TS_WIDTH(TW), .TDATA_WIDTH(DW),
    .START_SN_LSB(32), .STOP_SN_LSB(16)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(rst_n),
    .bus     (bus)
`ifdef EGR_LATENCY_TBL_STAT_EN
    ,
    .stat_count(stat_count),
    .stat_min  (stat_min),
    .stat_max  (stat_max)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Reference time: timestamp value the design samples at the next accept edge
  always @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 8'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic exp_lat(input logic [CW-1:0] cid, input logic [TW-1:0] lat);
    exp_q.push_back('{miss: 1'b0, cid: cid, data: lat, cyc: cyc + 3});
  endtask

  task automatic exp_miss(input logic [CW-1:0] cid);
    exp_q.push_back('{miss: 1'b1, cid: cid, data: '0, cyc: cyc + 3});
  endtask

  // Present start and/or end events for exactly one cycle (called at a negedge)
  task automatic drive(input bit s, input logic [CW-1:0] sc, input logic [SW-1:0] ssn,
                       input bit e, input logic [CW-1:0] ec, input logic [SW-1:0] esn);
    logic [DW-1:0] sd, ed;
    sd = '0; sd[CW-1:0] = sc; sd[32 +: SW] = ssn;
    ed = '0; ed[CW-1:0] = ec; ed[16 +: SW] = esn;
    bus.egr_meas_start_tvalid = s;
    bus.egr_meas_start_tdata  = sd;
    bus.egr_meas_end_tvalid   = e;
    bus.egr_meas_end_tdata    = ed;
    #1;
    if (s) chk("start_tready", 64'(bus.egr_meas_start_tready), 64'd1);
    if (e) chk("end_tready", 64'(bus.egr_meas_end_tready), 64'd1);
    @(negedge ap_clk);
    bus.egr_meas_start_tvalid = 1'b0;
    bus.egr_meas_end_tvalid   = 1'b0;
  endtask

  task automatic drv_start(input logic [CW-1:0] c, input logic [SW-1:0] sn);
    drive(1'b1, c, sn, 1'b0, '0, '0);
  endtask

  task automatic drv_end(input logic [CW-1:0] c, input logic [SW-1:0] sn);
    drive(1'b0, '0, '0, 1'b1, c, sn);
  endtask

  task automatic wait_ts(input logic [TW-1:0] t);
    int n = 0;
    while (tb_ts != t && n < 600) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 600) chk("wait_ts_timeout", 64'(tb_ts), 64'(t));
  endtask

  // Count cycles spent in INIT after a reset release or a cfg_clear
  task automatic init_len(input string name);
    int n = 0;
    int rdy_bad = 0;
    while (!bus.init_done && n < 100) begin
      if (bus.egr_meas_start_tready || bus.egr_meas_end_tready) rdy_bad++;
      n++;
      @(negedge ap_clk);
    end
    chk(name, 64'(n), 64'd16);
    chk({name, "_tready_low"}, 64'(rdy_bad), 64'd0);
    chk({name, "_tready_run"}, 64'({bus.egr_meas_start_tready, bus.egr_meas_end_tready}), 64'd3);
  endtask

  // Monitor: every result or mishit pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (rst_n) begin
        if (bus.err_start_overrun) ovr_seen++;
        if (bus.egr_latency_valid || bus.err_stop_mishit) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: valid=%0b mishit=%0b cid=%0d data=%0d, none expected",
                     bus.egr_latency_valid, bus.err_stop_mishit, bus.egr_latency_cid, bus.egr_latency_data);
          end else begin
            e = exp_q.pop_front();
            if (e.miss) begin
              if (!bus.err_stop_mishit || bus.egr_latency_valid || cyc != e.cyc) begin
                n_err++;
                $display("FAIL mishit cid%0d: got mishit=%0b valid=%0b cyc=%0d expected mishit=1 valid=0 cyc=%0d",
                         e.cid, bus.err_stop_mishit, bus.egr_latency_valid, cyc, e.cyc);
              end
            end else begin
              if (!bus.egr_latency_valid || bus.err_stop_mishit || bus.egr_latency_cid !== e.cid ||
                  bus.egr_latency_data !== e.data || cyc != e.cyc) begin
                n_err++;
                $display("FAIL latency cid%0d: got valid=%0b mishit=%0b cid=%0d data=%0d cyc=%0d expected cid=%0d data=%0d cyc=%0d",
                         e.cid, bus.egr_latency_valid, bus.err_stop_mishit, bus.egr_latency_cid,
                         bus.egr_latency_data, cyc, e.cid, e.data, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    bus.cfg_clear             = 1'b0;
    bus.egr_meas_start_tvalid = 1'b0;
    bus.egr_meas_start_tdata  = '0;
    bus.egr_meas_end_tvalid   = 1'b0;
    bus.egr_meas_end_tdata    = '0;

    repeat (3) @(negedge ap_clk);
    chk("rst_start_tready", 64'(bus.egr_meas_start_tready), 64'd0);
    chk("rst_end_tready", 64'(bus.egr_meas_end_tready), 64'd0);
    chk("rst_init_done", 64'(bus.init_done), 64'd0);
    chk("rst_lat_valid", 64'(bus.egr_latency_valid), 64'd0);
    chk("rst_lat_data", 64'(bus.egr_latency_data), 64'd0);
    chk("rst_lat_cid", 64'(bus.egr_latency_cid), 64'd0);
    chk("rst_errs", 64'({bus.err_stop_mishit, bus.err_start_overrun}), 64'd0);

    rst_n = 1'b1;
    init_len("init_cycles");

    // Basic hit
    wait_ts(8'd100); drv_start(4'd3, 16'h10);
    wait_ts(8'd150); exp_lat(4'd3, 8'd50); drv_end(4'd3, 16'h10);

    // Mishit with no entry; SN mismatch leaves the entry usable
    wait_ts(8'd160); exp_miss(4'd5); drv_end(4'd5, 16'h0);
    wait_ts(8'd170); drv_start(4'd6, 16'h20);
    wait_ts(8'd180); exp_miss(4'd6); drv_end(4'd6, 16'h21);
    wait_ts(8'd190); exp_lat(4'd6, 8'd20); drv_end(4'd6, 16'h20);

    // Overrun: later start wins; then back-to-back ends
    wait_ts(8'd200); drv_start(4'd2, 16'h1);
    wait_ts(8'd210); drv_start(4'd2, 16'h1);
    wait_ts(8'd230); exp_lat(4'd2, 8'd20); drv_end(4'd2, 16'h1);
    exp_miss(4'd2); drv_end(4'd2, 16'h1);

    // Timestamp wrap
    wait_ts(8'd250); drv_start(4'd7, 16'h5);
    wait_ts(8'd4);   exp_lat(4'd7, 8'd10); drv_end(4'd7, 16'h5);

    // Same-cycle start and end: end sees old entry, new entry survives
    wait_ts(8'd10); drv_start(4'd8, 16'h1);
    wait_ts(8'd20); exp_lat(4'd8, 8'd10); drive(1'b1, 4'd8, 16'h2, 1'b1, 4'd8, 16'h1);
    wait_ts(8'd30); exp_lat(4'd8, 8'd10); drv_end(4'd8, 16'h2);

    // Start one cycle before end is visible to the end
    wait_ts(8'd40); drv_start(4'd9, 16'h3);
    exp_lat(4'd9, 8'd1); drv_end(4'd9, 16'h3);

    // Start in the cycle the hit clears the same cid: start wins
    wait_ts(8'd50); drv_start(4'd10, 16'h1);
    wait_ts(8'd60); exp_lat(4'd10, 8'd10); drv_end(4'd10, 16'h1);
    drv_start(4'd10, 16'h4);
    wait_ts(8'd70); exp_lat(4'd10, 8'd9); drv_end(4'd10, 16'h4);

    // cfg_clear re-runs init and drops live entries
    wait_ts(8'd80); drv_start(4'd11, 16'h1);
    wait_ts(8'd85);
    bus.cfg_clear = 1'b1;
    @(negedge ap_clk);
    bus.cfg_clear = 1'b0;
    init_len("clear_init_cycles");
    exp_miss(4'd11); drv_end(4'd11, 16'h1);

`ifdef EGR_LATENCY_TBL_STAT_EN
    begin
      logic [TW-1:0] t;
      t = tb_ts; drv_start(4'd1, 16'h1); wait_ts(t + 8'd50); exp_lat(4'd1, 8'd50); drv_end(4'd1, 16'h1);
      t = tb_ts; drv_start(4'd2, 16'h2); wait_ts(t + 8'd20); exp_lat(4'd2, 8'd20); drv_end(4'd2, 16'h2);
      t = tb_ts; drv_start(4'd3, 16'h3); wait_ts(t + 8'd80); exp_lat(4'd3, 8'd80); drv_end(4'd3, 16'h3);
      repeat (4) @(negedge ap_clk);
      chk("stat_count", 64'(stat_count), 64'd3);
      chk("stat_min", 64'(stat_min), 64'd20);
      chk("stat_max", 64'(stat_max), 64'd80);
      bus.cfg_clear = 1'b1;
      @(negedge ap_clk);
      bus.cfg_clear = 1'b0;
      chk("stat_count_clr", 64'(stat_count), 64'd0);
      chk("stat_min_clr", 64'(stat_min), 64'hff);
      chk("stat_max_clr", 64'(stat_max), 64'd0);
      init_len("stat_clear_init_cycles");
    end
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge ap_clk);
    chk("overrun_pulses", 64'(ovr_seen), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
